frame_compositor: RTL

Pixel compositor for the ball/paddle game. It sits between the VGA scan generator and the video output. Each frame it snapshots the ball position, paddle bounds and wall bounds. It then turns every scanned pixel into an RGB colour through a 2-stage pipeline, and emits the one-cycle `newFrame` pulse that advances the ball trajectory logic during vertical blanking.

---
 rtl/frame_compositor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/frame_compositor.sv
// frame_compositor: turns each scanned pixel into an RGB colour (ball, paddle,
// wall or background) through a 2-stage pipeline. Geometry is snapshotted once
// per frame at the frame-start pixel. A one-cycle newFrame pulse follows the last
// visible pixel.
module frame_compositor #(
    parameter int          BALL_W     = 10,
    parameter int          BALL_H     = 10,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [23:0] BALL_RGB   = 24'hFFFFFF,
    parameter logic [23:0] PADDLE_RGB = 24'h00FF00,
    parameter logic [23:0] WALL_RGB   = 24'h0000FF,
    parameter logic [23:0] BG_RGB     = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixValid,
    input  logic [12:0] hCount,
    input  logic [12:0] vCount,
    input  logic [12:0] ballX,
    input  logic [12:0] ballY,
    input  logic [12:0] paddleLeft,
    input  logic [12:0] paddleRight,
    input  logic [12:0] paddleTop,
    input  logic [12:0] paddleBottom,
    input  logic [12:0] wallLeft,
    input  logic [12:0] wallRight,
    input  logic [12:0] wallTop,
    input  logic [12:0] wallBottom,
    output logic        newFrame,
    output logic [23:0] rgbOut,
    output logic        rgbValid
);

    // Ball half-extents. Left/top take the larger half for even sizes.
    localparam logic signed [13:0] BALL_LO_X = 14'(BALL_W >> 1);
    localparam logic signed [13:0] BALL_HI_X = 14'((BALL_W - 1) >> 1);
    localparam logic signed [13:0] BALL_LO_Y = 14'(BALL_H >> 1);
    localparam logic signed [13:0] BALL_HI_Y = 14'((BALL_H - 1) >> 1);
    localparam logic [12:0]        LAST_H    = 13'(H_ACTIVE - 1);
    localparam logic [12:0]        LAST_V    = 13'(V_ACTIVE - 1);

    // Per-frame shadow copies of the geometry inputs
    logic [12:0] r_ball_x, r_ball_y;
    logic [12:0] r_pad_l, r_pad_r, r_pad_t, r_pad_b;
    logic [12:0] r_wall_l, r_wall_r, r_wall_t, r_wall_b;
    logic        r_shadow_valid;

    // Stage-1 hit flags and valid bit
    logic        r_s1_ball, r_s1_paddle, r_s1_wall, r_s1_valid;

    // Effective geometry for this pixel: live inputs at frame start, shadow otherwise
    logic        w_fs;
    logic        w_geom_ok;
    logic [12:0] w_ball_x, w_ball_y;
    logic [12:0] w_pad_l, w_pad_r, w_pad_t, w_pad_b;
    logic [12:0] w_wall_l, w_wall_r, w_wall_t, w_wall_b;
    logic signed [13:0] w_h_s, w_v_s, w_bl, w_br, w_bt, w_bb;
    logic        w_hit_ball, w_hit_paddle, w_hit_wall;
    logic        w_last_pix;

    assign w_fs       = pixValid && (hCount == 13'd0) && (vCount == 13'd0);
    assign w_last_pix = pixValid && (hCount == LAST_H) && (vCount == LAST_V);
    assign w_geom_ok  = w_fs || r_shadow_valid;

    // Bypass mux so the frame-start pixel already sees the new geometry
    always_comb begin
        w_ball_x = w_fs ? ballX        : r_ball_x;
        w_ball_y = w_fs ? ballY        : r_ball_y;
        w_pad_l  = w_fs ? paddleLeft   : r_pad_l;
        w_pad_r  = w_fs ? paddleRight  : r_pad_r;
        w_pad_t  = w_fs ? paddleTop    : r_pad_t;
        w_pad_b  = w_fs ? paddleBottom : r_pad_b;
        w_wall_l = w_fs ? wallLeft     : r_wall_l;
        w_wall_r = w_fs ? wallRight    : r_wall_r;
        w_wall_t = w_fs ? wallTop      : r_wall_t;
        w_wall_b = w_fs ? wallBottom   : r_wall_b;
    end

    // Hit tests; ball box in 14-bit signed so it can extend past column/row 0
    always_comb begin
        w_h_s = $signed({1'b0, hCount});
        w_v_s = $signed({1'b0, vCount});
        w_bl  = $signed({1'b0, w_ball_x}) - BALL_LO_X;
        w_br  = $signed({1'b0, w_ball_x}) + BALL_HI_X;
        w_bt  = $signed({1'b0, w_ball_y}) - BALL_LO_Y;
        w_bb  = $signed({1'b0, w_ball_y}) + BALL_HI_Y;
        w_hit_ball   = (w_bl <= w_h_s) && (w_h_s <= w_br) &&
                       (w_bt <= w_v_s) && (w_v_s <= w_bb);
        w_hit_paddle = (w_pad_l <= hCount) && (hCount <= w_pad_r) &&
                       (w_pad_t <= vCount) && (vCount <= w_pad_b);
        w_hit_wall   = (hCount < w_wall_l) || (hCount > w_wall_r) ||
                       (vCount < w_wall_t) || (vCount > w_wall_b);
    end

    // Capture geometry at frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ball_x <= '0; r_ball_y <= '0;
            r_pad_l  <= '0; r_pad_r  <= '0; r_pad_t  <= '0; r_pad_b  <= '0;
            r_wall_l <= '0; r_wall_r <= '0; r_wall_t <= '0; r_wall_b <= '0;
            r_shadow_valid <= 1'b0;
        end else if (w_fs) begin
            r_ball_x <= ballX;      r_ball_y <= ballY;
            r_pad_l  <= paddleLeft; r_pad_r  <= paddleRight;
            r_pad_t  <= paddleTop;  r_pad_b  <= paddleBottom;
            r_wall_l <= wallLeft;   r_wall_r <= wallRight;
            r_wall_t <= wallTop;    r_wall_b <= wallBottom;
            r_shadow_valid <= 1'b1;
        end
    end

    // Stage 1: register hit flags; no geometry yet means plain background
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_ball   <= 1'b0;
            r_s1_paddle <= 1'b0;
            r_s1_wall   <= 1'b0;
            r_s1_valid  <= 1'b0;
        end else begin
            r_s1_ball   <= w_geom_ok && w_hit_ball;
            r_s1_paddle <= w_geom_ok && w_hit_paddle;
            r_s1_wall   <= w_geom_ok && w_hit_wall;
            r_s1_valid  <= pixValid;
        end
    end

    // Stage 2: priority colour mux, blanked when no pixel is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgbOut   <= 24'h0;
            rgbValid <= 1'b0;
        end else if (!r_s1_valid) begin
            rgbOut   <= 24'h0;
            rgbValid <= 1'b0;
        end else begin
            rgbValid <= 1'b1;
            if (r_s1_ball)        rgbOut <= BALL_RGB;
            else if (r_s1_paddle) rgbOut <= PADDLE_RGB;
            else if (r_s1_wall)   rgbOut <= WALL_RGB;
            else                  rgbOut <= BG_RGB;
        end
    end

    // End-of-frame pulse, one cycle after the last visible pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) newFrame <= 1'b0;
        else       newFrame <= w_last_pix;
    end

endmodule
